// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and constants for the memory stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // LO and HI are the only states that drive an SRAM phase
    function automatic logic is_active(input state_t s);
        return (s == LO) || (s == HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_ctrl.sv
// ============================================================================
// sram_ctrl : two-phase 16-bit SRAM sequencer, wait counter, pins and freeze
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_i,
    input  logic               store_i,
    input  logic [ADDR_W-2:0]  word_i,
    input  logic [31:0]        st_val_i,
    input  logic [SRAM_DW-1:0] sram_rdata_i,
    output logic               freeze_o,
    output state_t             state_o,
    output logic [31:0]        rdata_o,
    output logic [ADDR_W-1:0]  sram_addr_o,
    output logic [SRAM_DW-1:0] sram_wdata_o,
    output logic               sram_wdata_oe_o,
    output logic               sram_we_n_o
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Read data is sampled on the last cycle of each phase, when the SRAM guarantees it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = LO;
                    cnt_d   = '0;
                end
            end
            LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HI;
                    if (!store_i) data_d[15:0] = sram_rdata_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!store_i) data_d[31:16] = sram_rdata_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        freeze_o        = req_i && (state_q != DONE);
        state_o         = state_q;
        rdata_o         = data_q;
        sram_addr_o     = '0;
        sram_wdata_o    = '0;
        sram_wdata_oe_o = 1'b0;
        sram_we_n_o     = 1'b1;
        if (state_q == LO) begin
            sram_addr_o  = {word_i, 1'b0};
            sram_wdata_o = store_i ? st_val_i[15:0] : '0;
        end else if (state_q == HI) begin
            sram_addr_o  = {word_i, 1'b1};
            sram_wdata_o = store_i ? st_val_i[31:16] : '0;
        end
        if (is_active(state_q) && store_i) begin
            sram_wdata_oe_o = 1'b1;
            sram_we_n_o     = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : memory stage and MEM/WB register; optional read buffer via
//             MEM_RCACHE_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_W      = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        ALU_result,
    input  logic               wb_en,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [4:0]         dest,
    input  logic [31:0]        st_val,
    output logic               freeze,
    output logic [31:0]        pc_out,
    output logic               wb_en_out,
    output logic               mem_read_out,
    output logic [4:0]         dest_out,
    output logic [31:0]        alu_out,
    output logic [31:0]        mem_result,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    output logic               sram_wdata_oe,
    output logic               sram_we_n,
    input  logic [SRAM_DW-1:0] sram_rdata
);

    logic [31:0]       w_diff;
    logic [ADDR_W-2:0] w_word;
    logic              w_unused_diff;
    logic              w_store;
    logic              w_load;
    logic              w_hit;
    logic              w_freeze;
    state_t            w_state;
    logic [31:0]       w_rdata;
    logic [31:0]       w_load_data;

    // A simultaneous read and write is treated as a store
    assign w_store       = mem_write;
    assign w_load        = mem_read & ~mem_write;
    assign w_diff        = ALU_result - BASE_ADDR;
    assign w_word        = w_diff[ADDR_W:2];
    assign w_unused_diff = ^{w_diff[31:ADDR_W+1], w_diff[1:0]};

    sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .req_i           ((mem_read | mem_write) & ~w_hit),
        .store_i         (w_store),
        .word_i          (w_word),
        .st_val_i        (st_val),
        .sram_rdata_i    (sram_rdata),
        .freeze_o        (w_freeze),
        .state_o         (w_state),
        .rdata_o         (w_rdata),
        .sram_addr_o     (sram_addr),
        .sram_wdata_o    (sram_wdata),
        .sram_wdata_oe_o (sram_wdata_oe),
        .sram_we_n_o     (sram_we_n)
    );

`ifdef MEM_RCACHE_EN
    logic              rc_valid_q;
    logic [ADDR_W-2:0] rc_tag_q;
    logic [31:0]       rc_data_q;

    // A hit is only taken before any SRAM cycle starts for this load
    assign w_hit       = rc_valid_q && (rc_tag_q == w_word) && w_load && (w_state == IDLE);
    assign w_load_data = w_hit ? rc_data_q : w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_valid_q <= 1'b0;
            rc_tag_q   <= '0;
            rc_data_q  <= '0;
        end else if (w_state == DONE) begin
            if (w_load) begin
                rc_valid_q <= 1'b1;
                rc_tag_q   <= w_word;
                rc_data_q  <= w_rdata;
            end else if (w_store && rc_valid_q && (rc_tag_q == w_word)) begin
                rc_data_q  <= st_val;
            end
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_load_data = w_rdata;
`endif

    logic [31:0] pc_q;
    logic        wb_en_q;
    logic        mem_read_q;
    logic [4:0]  dest_q;
    logic [31:0] alu_q;
    logic [31:0] mem_result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            dest_q       <= '0;
            alu_q        <= '0;
            mem_result_q <= '0;
        end else if (w_freeze) begin
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            pc_q         <= pc_in;
            wb_en_q      <= wb_en;
            mem_read_q   <= mem_read;
            dest_q       <= dest;
            alu_q        <= ALU_result;
            mem_result_q <= w_load_data;
        end
    end

    assign freeze       = w_freeze;
    assign pc_out       = pc_q;
    assign wb_en_out    = wb_en_q;
    assign mem_read_out = mem_read_q;
    assign dest_out     = dest_q;
    assign alu_out      = alu_q;
    assign mem_result   = mem_result_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : vector table plus scoreboard bench for mem_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_pkg::*;

    localparam int WAIT   = 2;
    localparam int ADDR_W = 18;
    localparam int MEMF   = 1 + 2 * WAIT;
`ifdef MEM_RCACHE_EN
    localparam int HITF   = 0;
`else
    localparam int HITF   = MEMF;
`endif

    typedef struct {
        logic        wb;
        logic        rd;
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] pc;
        logic        chk_mr;
        logic [31:0] exp_mr;
        int          exp_frz;
        logic [17:0] exp_lo;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pc_in, ALU_result, st_val;
    logic              wb_en, mem_read, mem_write;
    logic [4:0]        dest;
    logic              freeze;
    logic [31:0]       pc_out, alu_out, mem_result;
    logic              wb_en_out, mem_read_out;
    logic [4:0]        dest_out;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wdata, sram_rdata;
    logic              sram_wdata_oe, sram_we_n;

    logic [15:0]       sram_mem [0:(1<<ADDR_W)-1];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [15:0]       pre_data = '0;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t vecs[12];
    logic [ADDR_W-1:0] tr_addr  [64];
    logic [15:0]       tr_wdata [64];
    logic              tr_oe    [64];

    always #5 clk = ~clk;

    mem_stage #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(WAIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .ALU_result(ALU_result), .wb_en(wb_en),
        .mem_read(mem_read), .mem_write(mem_write), .dest(dest), .st_val(st_val),
        .freeze(freeze), .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
        .dest_out(dest_out), .alu_out(alu_out), .mem_result(mem_result),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_we_n(sram_we_n), .sram_rdata(sram_rdata)
    );

    // Off-chip SRAM model with a preload port used during reset
    assign sram_rdata = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (pre_en)          sram_mem[pre_addr]  <= pre_data;
        else if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wb, rd, wr, input logic [4:0] d,
                                input logic [31:0] alu, st, pc, input logic cm,
                                input logic [31:0] mr, input int frz, input logic [17:0] lo);
        vec_t v;
        v.wb = wb; v.rd = rd; v.wr = wr; v.dest = d; v.alu = alu; v.st = st; v.pc = pc;
        v.chk_mr = cm; v.exp_mr = mr; v.exp_frz = frz; v.exp_lo = lo;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        int   frz;
        int   we_low;
        vec_t e;
        @(negedge clk);
        wb_en = v.wb; mem_read = v.rd; mem_write = v.wr; dest = v.dest;
        ALU_result = v.alu; st_val = v.st; pc_in = v.pc;
        sb.push_back(v);
        frz = 0; we_low = 0;
        #1;
        while (freeze === 1'b1 && frz < 40) begin
            tr_addr[frz] = sram_addr; tr_wdata[frz] = sram_wdata; tr_oe[frz] = sram_wdata_oe;
            if (!sram_we_n) we_low++;
            if (frz > 0) chk("bubble", {30'd0, wb_en_out, mem_read_out}, 32'd0);
            @(negedge clk); #1;
            frz++;
        end
        if (frz >= 40) begin
            checks++; errors++;
            $display("FAIL freeze_timeout: freeze still high after %0d cycles, pc %h", frz, v.pc);
        end
        chk("freeze_cycles", 32'(frz), 32'(v.exp_frz));
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("wb_en_out", {31'd0, wb_en_out}, {31'd0, e.wb});
        chk("mem_read_out", {31'd0, mem_read_out}, {31'd0, e.rd});
        chk("dest_out", {27'd0, dest_out}, {27'd0, e.dest});
        chk("alu_out", alu_out, e.alu);
        chk("pc_out", pc_out, e.pc);
        if (e.chk_mr) chk("mem_result", mem_result, e.exp_mr);
        if (frz == MEMF && e.exp_frz == MEMF) begin
            chk("lo_addr", 32'(tr_addr[1]), 32'(e.exp_lo));
            chk("hi_addr", 32'(tr_addr[WAIT+1]), 32'(e.exp_lo + 18'd1));
            chk("we_low_cycles", 32'(we_low), e.wr ? 32'(2 * WAIT) : 32'd0);
            chk("idle_oe", {31'd0, tr_oe[0]}, 32'd0);
            if (e.wr) begin
                chk("lo_wdata", {16'd0, tr_wdata[1]}, {16'd0, e.st[15:0]});
                chk("hi_wdata", {16'd0, tr_wdata[WAIT+1]}, {16'd0, e.st[31:16]});
                chk("store_oe", {31'd0, tr_oe[WAIT]}, 32'd1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_en = 0; mem_read = 0; mem_write = 0; dest = '0;
        ALU_result = '0; st_val = '0; pc_in = '0;
        @(negedge clk); pre_en = 1'b1; pre_addr = 18'h3FE00; pre_data = 16'h1234;
        @(negedge clk); pre_addr = 18'h3FE01; pre_data = 16'h5678;
        @(negedge clk); pre_en = 1'b0;
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_wb_en_out", {31'd0, wb_en_out}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'd0, sram_wdata_oe}, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        rst = 1'b0;

        //            wb rd wr dest   alu            st             pc        cm mr             frz   lo
        vecs[0]  = mk(1, 0, 0, 5'd5,  32'h0000002A,  32'h0,         32'h100,  0, 32'h0,         0,    18'h0);
        vecs[1]  = mk(1, 0, 0, 5'd31, 32'hFFFFFFFF,  32'h0,         32'h104,  0, 32'h0,         0,    18'h0);
        vecs[2]  = mk(0, 0, 0, 5'd0,  32'h00000000,  32'h0,         32'h108,  0, 32'h0,         0,    18'h0);
        vecs[3]  = mk(0, 0, 1, 5'd0,  32'd1028,      32'hDEADBEEF,  32'h10C,  0, 32'h0,         MEMF, 18'h2);
        vecs[4]  = mk(1, 1, 0, 5'd7,  32'd1028,      32'h0,         32'h110,  1, 32'hDEADBEEF,  MEMF, 18'h2);
        vecs[5]  = mk(1, 1, 0, 5'd8,  32'd1028,      32'h0,         32'h114,  1, 32'hDEADBEEF,  HITF, 18'h2);
        vecs[6]  = mk(0, 0, 1, 5'd0,  32'd1028,      32'h00000001,  32'h118,  0, 32'h0,         MEMF, 18'h2);
        vecs[7]  = mk(1, 1, 0, 5'd9,  32'd1028,      32'h0,         32'h11C,  1, 32'h00000001,  HITF, 18'h2);
        vecs[8]  = mk(1, 1, 0, 5'd10, 32'h00000000,  32'h0,         32'h120,  1, 32'h56781234,  MEMF, 18'h3FE00);
        vecs[9]  = mk(0, 1, 1, 5'd11, 32'd1032,      32'hCAFEF00D,  32'h124,  0, 32'h0,         MEMF, 18'h4);
        vecs[10] = mk(1, 1, 0, 5'd12, 32'd1035,      32'h0,         32'h128,  1, 32'hCAFEF00D,  MEMF, 18'h4);
        vecs[11] = mk(1, 0, 0, 5'd13, 32'h12345678,  32'h0,         32'h12C,  0, 32'h0,         0,    18'h0);

        for (int i = 0; i < 12; i++) issue(vecs[i]);

        // Reset in the middle of the high-half write of a store
        @(negedge clk);
        wb_en = 0; mem_read = 0; mem_write = 1; dest = 5'd3;
        ALU_result = 32'd1036; st_val = 32'h12345678; pc_in = 32'h200;
        for (int n = 0; n < 20 && !(sram_addr == 18'h7 && sram_we_n == 1'b0); n++) @(negedge clk);
        chk("reached_hi", 32'(sram_addr), 32'h7);
        rst = 1'b1; mem_write = 0; pc_in = '0; ALU_result = '0; st_val = '0; dest = '0;
        @(posedge clk); #1;
        chk("abort_state", 32'(dut.u_ctrl.state_q), 32'(IDLE));
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_oe", {31'd0, sram_wdata_oe}, 32'd0);
        chk("abort_freeze", {31'd0, freeze}, 32'd0);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_pc_out", pc_out, 32'd0);
        chk("abort_alu_out", alu_out, 32'd0);
        chk("abort_mem_result", mem_result, 32'd0);
        chk("abort_dest_out", {27'd0, dest_out}, 32'd0);
        chk("abort_outs", {30'd0, wb_en_out, mem_read_out}, 32'd0);
        @(negedge clk); rst = 1'b0;
        issue(mk(1, 0, 0, 5'd21, 32'h0BADF00D, 32'h0, 32'h300, 0, 32'h0, 0, 18'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
